seg7_scan_decoder: RTL and testbench
====================================

Name: seg7_scan_decoder

Overview:
Receive-side counterpart of the hex-to-segment encoder path. It samples a time-multiplexed, active-low 7-segment bus (segments plus one-hot active-low anodes), waits for each digit to settle, and decodes each segment pattern back into a hex nibble. It assembles one full frame of DIGITS nibbles and presents it on a valid/ready output. It is used for board loopback self-test and as a bench-side monitor of the Fibonacci display path.

Parameters:
DIGITS, 4, number of multiplexed digits; data_out width is 4*DIGITS.
STABLE_CYCLES, 4, consecutive identical synchronized samples required before a digit is accepted (range 2..255).

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
seg_in  in  7  active-low segments, bit6=a through bit0=g; asynchronous to clk.
an_in  in  DIGITS  active-low one-hot anode enables, bit i = digit i (nibble i); asynchronous.
data_out  out  4*DIGITS  decoded frame; nibble i = data_out[4i+3:4i].
out_valid  out  1  frame available; held until accepted.
out_ready  in  1  consumer accept.
pattern_err  out  1  frame contains at least one undecodable pattern; valid with out_valid.
seq_err  out  1  one-cycle pulse on an anode sequence violation.
overrun  out  1  sticky; a frame was dropped because out_valid was pending; cleared by reset only.

Behaviour:
- Reset values (asynchronous): data_out=0, out_valid=0, pattern_err=0, seq_err=0, overrun=0, FSM=IDLE, synchronizers=all-ones (blank).
- seg_in and an_in each pass through a 2-flop synchronizer. Total input latency is 2 cycles.
- Stability filter:
  - Counter resets whenever the synchronized {an,seg} changes.
  - When the counter reaches STABLE_CYCLES-1, it emits a single accept strobe.
  - No further strobe is emitted until the input changes.
- Anode classification at the strobe:
  - All ones = blank gap; ignored.
  - Exactly one zero = digit index k.
  - More than one zero = seq_err pulse, go to IDLE.
- Decode uses the fixed table 0..F (same encoding the transmit side uses, e.g. 0=0000001, 8=0000000, F=0111000).
  - Any other pattern, including 1111111, is invalid. The nibble is stored as 0 and the frame's pattern flag is set.
- FSM states:
  - IDLE: wait for an accepted strobe with k=0. Store nibble 0, set expected=1, go to CAPTURE. Strobes with k≠0 are ignored (resynchronization, no error).
  - CAPTURE: a strobe with k==expected stores the nibble and increments expected. After k==DIGITS-1, go to PRESENT.
    - A strobe with k==0 restarts the frame: nibble 0 is stored, expected=1, seq_err pulses.
    - Any other k pulses seq_err and goes to IDLE.
  - PRESENT: load the assembled nibbles into data_out, load pattern_err, and set out_valid in the same cycle. Go to IDLE immediately; capture continues into a shadow buffer.
- Output handshake:
  - out_valid&&out_ready completes the transfer; out_valid clears next cycle unless a new frame completes in that same cycle.
  - data_out and pattern_err are stable while out_valid=1 and !out_ready.
  - A frame completing while out_valid=1 and !out_ready is dropped, overrun is set, and the held data is unchanged.
  - A frame completing in the same cycle as acceptance loads normally (no overrun).
- DIGITS=1: the IDLE strobe with k=0 goes directly to PRESENT.
- Reset asserted mid-frame discards the partial frame.

Optional Feature:
SEG7_ERR_COUNT_EN
- Defined: adds output err_count[7:0]. It is a saturating count (sticks at 255) of seq_err pulses plus frames delivered with pattern_err=1. It is reset to 0 by rst_n and also cleared by an additional input err_clr, which takes priority over increment.
- Undefined: neither port exists and no counter logic is present.

Decomposition:
- Package seg7_pkg:
  - localparam segment constants SEG_HEX[16] and SEG_BLANK=7'b1111111.
  - function seg_to_nibble returning {valid, nibble[3:0]}.
  - typedef enum logic [1:0] {IDLE, CAPTURE, PRESENT} seg7_dec_state_t.
- Sub-module: seg7_stable_filter, containing the synchronizers plus the stability counter and emitting the accept strobe with the sampled {an,seg}.

Test Plan:
- STABLE_CYCLES=4, drive digits 0..3 with patterns for 1,2,3,4, each held 10 cycles with 2-cycle blank gaps, out_ready=1 -> out_valid pulses once, data_out=16'h4321, pattern_err=0.
- Digit 2 held for only 3 cycles in the middle of a frame -> not accepted; the next accepted k=3 causes a seq_err pulse and no out_valid.
- Digit 1 driven with 7'b1111110 -> frame delivered with data_out nibble1=0 and pattern_err=1.
- an_in=4'b1100 held stable -> seq_err pulse, FSM returns to IDLE; a later clean frame of A,B,C,D -> data_out=16'hDCBA.
- out_ready=0 while two complete frames arrive (16'h1111 then 16'h2222) -> data_out stays 16'h1111, overrun=1; raise out_ready -> one transfer, then out_valid=0.
- Assert rst_n=0 after two digits are captured, release, send 16'h00F0 -> only 16'h00F0 is delivered; all outputs read 0 during reset.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared segment encoding, decode helper and decoder state type for the 7-segment scan receive path.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low, bit6=a .. bit0=g; must match the transmit-side encoder.
    localparam logic [6:0] SEG_HEX [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef enum logic [1:0] {IDLE, CAPTURE, PRESENT} seg7_dec_state_t;

    // Returns {valid, nibble}; an unknown pattern yields {0, 4'h0}.
    function automatic logic [4:0] seg_to_nibble(input logic [6:0] seg);
        logic [4:0] res;
        res = 5'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_HEX[i]) res = {1'b1, 4'(i)};
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// Two-flop synchronizer on the raw {an,seg} bus plus a settle counter that
// emits one accept strobe per stable value.
module seg7_stable_filter #(
    parameter int W             = 11,
    parameter int STABLE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_raw,
    output logic         o_strobe,
    output logic [W-1:0] o_sample
);

    localparam logic [7:0] CNT_ACC = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

    logic [W-1:0] r_sync1;
    logic [W-1:0] r_sync2;
    logic [7:0]   r_cnt;

    // Counter saturates one past the accept point so the strobe fires once per value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_cnt   <= 8'd0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync1 != r_sync2)
                r_cnt <= 8'd0;
            else if (r_cnt != CNT_MAX)
                r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_strobe = (r_cnt == CNT_ACC);
    assign o_sample = r_sync2;

endmodule

// File: rtl/seg7_scan_decoder.sv
// Decodes a multiplexed active-low 7-segment bus back into hex frames on a valid/ready output.
// Optional SEG7_ERR_COUNT_EN adds err_clr / err_count[7:0] (saturating error counter).
//
// state   | meaning
// IDLE    | waiting for digit 0 to start a frame
// CAPTURE | collecting digits 1..DIGITS-1 in order
// PRESENT | frame complete, hand over to the output register
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     an_in,
    output logic [4*DIGITS-1:0]   data_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  pattern_err,
    output logic                  seq_err,
    output logic                  overrun
`ifdef SEG7_ERR_COUNT_EN
    ,
    input  logic                  err_clr,
    output logic [7:0]            err_count
`endif
);

    localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic                  w_strobe;
    logic [DIGITS+6:0]     w_sample;
    logic [DIGITS-1:0]     w_an;
    logic [6:0]            w_seg;
    logic [4:0]            w_dec;
    logic                  w_blank;
    logic                  w_one;
    logic                  w_multi;
    logic [KW-1:0]         w_k;
    logic                  w_last;

    seg7_dec_state_t       r_state;
    seg7_dec_state_t       w_state_nxt;
    logic [KW-1:0]         r_exp;
    logic [4*DIGITS-1:0]   r_frame;
    logic                  r_perr;

    logic                  w_start;
    logic                  w_store;
    logic                  w_seq_set;
    logic                  w_present;
    logic                  w_load;

    seg7_stable_filter #(
        .W             (DIGITS + 7),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_raw    ({an_in, seg_in}),
        .o_strobe (w_strobe),
        .o_sample (w_sample)
    );

    assign w_an    = w_sample[DIGITS+6:7];
    assign w_seg   = w_sample[6:0];
    assign w_dec   = seg_to_nibble(w_seg);
    assign w_blank = &w_an;
    assign w_one   = $onehot(~w_an);
    assign w_multi = !w_blank && !w_one;
    assign w_last  = (w_k == KW'(DIGITS - 1));

    always_comb begin
        w_k = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!w_an[i]) w_k = KW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_strobe && w_one && w_k == '0)
                    w_state_nxt = (DIGITS == 1) ? PRESENT : CAPTURE;
            end
            CAPTURE: begin
                if (w_strobe && !w_blank) begin
                    if (w_multi)
                        w_state_nxt = IDLE;
                    else if (w_k == '0)
                        w_state_nxt = CAPTURE;
                    else if (w_k == r_exp)
                        w_state_nxt = w_last ? PRESENT : CAPTURE;
                    else
                        w_state_nxt = IDLE;
                end
            end
            PRESENT: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_start   = 1'b0;
        w_store   = 1'b0;
        w_seq_set = 1'b0;
        w_present = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_strobe) begin
                    w_seq_set = w_multi;
                    w_start   = w_one && (w_k == '0);
                end
            end
            CAPTURE: begin
                if (w_strobe && !w_blank) begin
                    if (w_multi) begin
                        w_seq_set = 1'b1;
                    end else if (w_k == '0) begin
                        w_start   = 1'b1;
                        w_seq_set = 1'b1;
                    end else if (w_k == r_exp) begin
                        w_store   = 1'b1;
                    end else begin
                        w_seq_set = 1'b1;
                    end
                end
            end
            PRESENT: w_present = 1'b1;
            default: ;
        endcase
    end

    // r_frame doubles as the shadow buffer: it is only rewritten after PRESENT has copied it out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame <= '0;
            r_perr  <= 1'b0;
            r_exp   <= '0;
        end else if (w_start) begin
            r_frame[3:0] <= w_dec[3:0];
            r_perr       <= !w_dec[4];
            r_exp        <= KW'(1);
        end else if (w_store) begin
            r_frame[w_k*4 +: 4] <= w_dec[3:0];
            r_perr              <= r_perr | !w_dec[4];
            r_exp               <= r_exp + KW'(1);
        end
    end

    assign w_load = w_present && (!out_valid || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out    <= '0;
            out_valid   <= 1'b0;
            pattern_err <= 1'b0;
            seq_err     <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            seq_err <= w_seq_set;
            if (w_load) begin
                data_out    <= r_frame;
                pattern_err <= r_perr;
                out_valid   <= 1'b1;
            end else begin
                if (w_present) overrun <= 1'b1;
                if (out_valid && out_ready) out_valid <= 1'b0;
            end
        end
    end

`ifdef SEG7_ERR_COUNT_EN
    logic w_err_evt;
    assign w_err_evt = w_seq_set || (w_load && r_perr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_count <= 8'd0;
        else if (err_clr)
            err_count <= 8'd0;
        else if (w_err_evt && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: directed scenarios plus randomized frames
// compared against a frame-level model of what the transmit side sent.
module tb_seg7_scan_decoder;

    localparam int DIGITS = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] data_out;
    logic        out_valid;
    logic        out_ready;
    logic        pattern_err;
    logic        seq_err;
    logic        overrun;
`ifdef SEG7_ERR_COUNT_EN
    logic        err_clr;
    logic [7:0]  err_count;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [6:0]  enc [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    logic [6:0]  bad_pats [4] = '{7'b1111110, 7'b1111111, 7'b1010101, 7'b0110110};

    logic [16:0] got_q[$];
    logic [16:0] exp_q[$];
    int          seq_cnt = 0;

    always #5 clk = ~clk;

    seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .data_out    (data_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .pattern_err (pattern_err),
        .seq_err     (seq_err),
        .overrun     (overrun)
`ifdef SEG7_ERR_COUNT_EN
        ,
        .err_clr     (err_clr),
        .err_count   (err_count)
`endif
    );

    // Records every completed transfer and every seq_err pulse for the tests to inspect.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) got_q.push_back({pattern_err, data_out});
            if (seq_err) seq_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int cyc);
        if (cyc > 0) begin
            an_in  = an;
            seg_in = seg;
            tick(cyc);
        end
    endtask

    task automatic send_digit(input int k, input logic [6:0] seg, input int hold, input int gap);
        drive(~(4'b0001 << k), seg, hold);
        drive(4'hF, 7'h7F, gap);
    endtask

    task automatic send_frame(input logic [15:0] val, input logic [3:0] bad, input int hold, input int gap);
        for (int i = 0; i < DIGITS; i++)
            send_digit(i, bad[i] ? bad_pats[0] : enc[val[4*i +: 4]], hold, gap);
    endtask

    // What the receiver should reconstruct: undecodable digits read as 0 and flag the frame.
    function automatic logic [16:0] model_frame(input logic [15:0] val, input logic [3:0] bad);
        logic [15:0] d;
        d = val;
        for (int i = 0; i < DIGITS; i++)
            if (bad[i]) d[4*i +: 4] = 4'h0;
        return {|bad, d};
    endfunction

    task automatic wait_got(input int n);
        int budget;
        budget = 80;
        while (got_q.size() < n && budget > 0) begin
            tick(1);
            budget--;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        an_in = 4'b1110;
        seg_in = enc[3];
        tick(3);
        vectors++; if (data_out !== 16'h0) begin miscompares++; $display("FAIL reset_data_out got %h want 0000", data_out); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        vectors++; if (pattern_err !== 1'b0) begin miscompares++; $display("FAIL reset_pattern_err got %b want 0", pattern_err); end
        vectors++; if (seq_err !== 1'b0) begin miscompares++; $display("FAIL reset_seq_err got %b want 0", seq_err); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got %b want 0", overrun); end
        an_in = 4'hF;
        seg_in = 7'h7F;
        tick(1);
        rst_n = 1'b1;
        tick(4);
    endtask

    task automatic test_basic;
        int s0;
        logic [16:0] got;
        s0 = seq_cnt;
        got_q.delete();
        send_frame(16'h4321, 4'b0000, 10, 2);
        wait_got(1);
        got = (got_q.size() > 0) ? got_q[0] : 17'bx;
        vectors++; if (got !== {1'b0, 16'h4321}) begin miscompares++; $display("FAIL basic_frame got %h want %h", got, {1'b0, 16'h4321}); end
        tick(10);
        vectors++; if (got_q.size() !== 1) begin miscompares++; $display("FAIL basic_count got %0d want 1", got_q.size()); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_valid_clear got %b want 0", out_valid); end
        vectors++; if (seq_cnt - s0 !== 0) begin miscompares++; $display("FAIL basic_seq got %0d want 0", seq_cnt - s0); end
    endtask

    task automatic test_short_digit;
        int s0;
        s0 = seq_cnt;
        got_q.delete();
        send_digit(0, enc[1], 10, 2);
        send_digit(1, enc[2], 10, 2);
        send_digit(2, enc[3], 3, 2);
        send_digit(3, enc[4], 10, 2);
        tick(10);
        vectors++; if (seq_cnt - s0 !== 1) begin miscompares++; $display("FAIL short_seq got %0d want 1", seq_cnt - s0); end
        vectors++; if (got_q.size() !== 0) begin miscompares++; $display("FAIL short_frames got %0d want 0", got_q.size()); end
    endtask

    task automatic test_bad_pattern;
        logic [16:0] got;
        got_q.delete();
        send_frame(16'h4321, 4'b0010, 10, 2);
        wait_got(1);
        got = (got_q.size() > 0) ? got_q[0] : 17'bx;
        vectors++; if (got[15:0] !== 16'h4301) begin miscompares++; $display("FAIL badpat_data got %h want 4301", got[15:0]); end
        vectors++; if (got[16] !== 1'b1) begin miscompares++; $display("FAIL badpat_flag got %b want 1", got[16]); end
    endtask

    task automatic test_multi_anode;
        int s0;
        logic [16:0] got;
        s0 = seq_cnt;
        got_q.delete();
        drive(4'b1100, enc[5], 10);
        drive(4'hF, 7'h7F, 2);
        tick(4);
        vectors++; if (seq_cnt - s0 !== 1) begin miscompares++; $display("FAIL multi_seq got %0d want 1", seq_cnt - s0); end
        send_frame(16'hDCBA, 4'b0000, 10, 2);
        wait_got(1);
        got = (got_q.size() > 0) ? got_q[0] : 17'bx;
        vectors++; if (got !== {1'b0, 16'hDCBA}) begin miscompares++; $display("FAIL multi_frame got %h want %h", got, {1'b0, 16'hDCBA}); end
        vectors++; if (seq_cnt - s0 !== 1) begin miscompares++; $display("FAIL multi_seq_after got %0d want 1", seq_cnt - s0); end
    endtask

    task automatic test_overrun;
        logic [16:0] got;
        got_q.delete();
        out_ready = 1'b0;
        send_frame(16'h1111, 4'b0000, 10, 2);
        send_frame(16'h2222, 4'b0000, 10, 2);
        tick(10);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL ovr_valid_held got %b want 1", out_valid); end
        vectors++; if (data_out !== 16'h1111) begin miscompares++; $display("FAIL ovr_data_held got %h want 1111", data_out); end
        vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_flag got %b want 1", overrun); end
        vectors++; if (got_q.size() !== 0) begin miscompares++; $display("FAIL ovr_no_transfer got %0d want 0", got_q.size()); end
        out_ready = 1'b1;
        tick(3);
        got = (got_q.size() > 0) ? got_q[0] : 17'bx;
        vectors++; if (got_q.size() !== 1) begin miscompares++; $display("FAIL ovr_transfers got %0d want 1", got_q.size()); end
        vectors++; if (got !== {1'b0, 16'h1111}) begin miscompares++; $display("FAIL ovr_frame got %h want %h", got, {1'b0, 16'h1111}); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ovr_valid_clear got %b want 0", out_valid); end
        vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_sticky got %b want 1", overrun); end
    endtask

    task automatic test_reset_midframe;
        int s0;
        logic [16:0] got;
        send_digit(0, enc[5], 10, 2);
        send_digit(1, enc[6], 10, 2);
        rst_n = 1'b0;
        tick(2);
        vectors++; if (data_out !== 16'h0) begin miscompares++; $display("FAIL rstmid_data_out got %h want 0000", data_out); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
        vectors++; if (pattern_err !== 1'b0) begin miscompares++; $display("FAIL rstmid_pattern_err got %b want 0", pattern_err); end
        vectors++; if (seq_err !== 1'b0) begin miscompares++; $display("FAIL rstmid_seq_err got %b want 0", seq_err); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL rstmid_overrun got %b want 0", overrun); end
        rst_n = 1'b1;
        tick(2);
        s0 = seq_cnt;
        got_q.delete();
        send_frame(16'h00F0, 4'b0000, 10, 2);
        wait_got(1);
        tick(5);
        got = (got_q.size() > 0) ? got_q[0] : 17'bx;
        vectors++; if (got !== {1'b0, 16'h00F0}) begin miscompares++; $display("FAIL rstmid_frame got %h want %h", got, {1'b0, 16'h00F0}); end
        vectors++; if (got_q.size() !== 1) begin miscompares++; $display("FAIL rstmid_count got %0d want 1", got_q.size()); end
        vectors++; if (seq_cnt - s0 !== 0) begin miscompares++; $display("FAIL rstmid_seq got %0d want 0", seq_cnt - s0); end
    endtask

    task automatic test_random;
        int s0;
        logic [15:0] val;
        logic [3:0]  bad;
        logic [6:0]  seg;
        got_q.delete();
        exp_q.delete();
        s0 = seq_cnt;
        for (int f = 0; f < 8; f++) begin
            val = 16'($urandom);
            bad = ($urandom_range(0, 2) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
            exp_q.push_back(model_frame(val, bad));
            for (int i = 0; i < DIGITS; i++) begin
                seg = bad[i] ? bad_pats[$urandom_range(0, 3)] : enc[val[4*i +: 4]];
                send_digit(i, seg, $urandom_range(5, 12), $urandom_range(0, 3));
            end
        end
        wait_got(8);
        tick(5);
        vectors++; if (got_q.size() !== 8) begin miscompares++; $display("FAIL rand_count got %0d want 8", got_q.size()); end
        for (int f = 0; f < 8; f++) begin
            vectors++;
            if (f >= got_q.size() || got_q[f] !== exp_q[f]) begin
                miscompares++;
                $display("FAIL rand_frame%0d got %h want %h", f, (f < got_q.size()) ? got_q[f] : 17'bx, exp_q[f]);
            end
        end
        vectors++; if (seq_cnt - s0 !== 0) begin miscompares++; $display("FAIL rand_seq got %0d want 0", seq_cnt - s0); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL rand_overrun got %b want 0", overrun); end
    endtask

    initial begin
        rst_n     = 1'b0;
        an_in     = 4'hF;
        seg_in    = 7'h7F;
        out_ready = 1'b1;
`ifdef SEG7_ERR_COUNT_EN
        err_clr   = 1'b0;
`endif
        @(posedge clk);
        #2;
        test_reset;
        test_basic;
        test_short_digit;
        test_bad_pattern;
        test_multi_anode;
        test_overrun;
        test_reset_midframe;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
